// File: rtl/rv_fetch_pkg.sv
// Shared types and helpers for the RV32IC fetch stage.
package rv_fetch_pkg;

  typedef logic [31:0] pc_t;
  typedef logic [15:0] hword_t;

  localparam pc_t RESET_PC = 32'h0000_0000;

  // A halfword starts a compressed instruction unless its two low bits are 2'b11.
  function automatic logic is_rvc(hword_t hw);
    return hw[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/fetch_hbuf.sv
// Three-entry halfword FIFO between the instruction memory and the issue logic.
// In one cycle it can drop 0..2 entries from the front and append 0..2 at the
// back; the drop is applied first, so a full buffer can pop and push together.
module fetch_hbuf
  import rv_fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic [1:0] pop_n,
  input  logic [1:0] push_n,
  input  hword_t     push_d0,
  input  hword_t     push_d1,
  output logic [1:0] cnt,
  output hword_t     head0,
  output hword_t     head1
);

  hword_t     q0, q1, q2;
  hword_t     s0, s1, s2;
  hword_t     n0, n1, n2;
  logic [1:0] rem;

  // Shift surviving entries toward the head after removing popped ones.
  always_comb begin
    s0 = q0;
    s1 = q1;
    s2 = q2;
    case (pop_n)
      2'd1: begin
        s0 = q1;
        s1 = q2;
      end
      2'd2: begin
        s0 = q2;
        s1 = q2;
      end
      default: ;
    endcase
    rem = cnt - pop_n;
  end

  // Append pushed halfwords directly behind the survivors.
  always_comb begin
    n0 = s0;
    n1 = s1;
    n2 = s2;
    if (push_n != 2'd0) begin
      case (rem)
        2'd0:    n0 = push_d0;
        2'd1:    n1 = push_d0;
        default: n2 = push_d0;
      endcase
    end
    if (push_n == 2'd2) begin
      case (rem)
        2'd0:    n1 = push_d1;
        default: n2 = push_d1;
      endcase
    end
  end

  // Storage and occupancy; flush empties the queue.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      cnt <= 2'd0;
      q0  <= '0;
      q1  <= '0;
      q2  <= '0;
    end else begin
      cnt <= rem + push_n;
      q0  <= n0;
      q1  <= n1;
      q2  <= n2;
    end
  end

  assign head0 = q0;
  assign head1 = q1;

endmodule

// File: rtl/fetch_align.sv
// RV32IC fetch stage: addresses instruction memory, realigns halfwords into
// 16/32-bit instructions (including word-straddling ones) and holds the IF/ID
// register. Redirects from execute flush the buffer and restart fetch.
//
// IF/ID handshake: if_valid says the IF/ID register holds an instruction; it is
// consumed on a rising edge where if_valid && id_ready (and no redirect). While
// if_valid && !id_ready every if_* output holds its value.
module fetch_align
  import rv_fetch_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter int              IMEM_AW  = 10,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(rv_fetch_pkg::RESET_PC)
) (
  input  logic               clk,
  input  logic               rst,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic               imem_we,
  input  logic               redirect_vld,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               id_ready,
  output logic               if_valid,
  output logic [31:0]        if_instr,
  output logic               if_is_c,
  output logic [PC_W-1:0]    if_pc
);

  logic [PC_W-1:0] fetch_pc, buf_pc, view_pc;
  logic [1:0]      hb_cnt, inc_n, take_n, pop_n, skip_n, push_n;
  logic [2:0]      view_cnt;
  hword_t          hb0, hb1, inc0, inc1, v0, v1, push_d0, push_d1;
  logic            fetch_en, head_c, head_ok, slot_free, issue;

  // Only fetch when a whole word is guaranteed to fit behind the buffered halfwords.
  assign fetch_en  = (hb_cnt <= 2'd1) && !redirect_vld;
  assign imem_addr = fetch_pc[IMEM_AW+1:2];
  assign imem_we   = 1'b0;

  fetch_hbuf u_hbuf (
    .clk     (clk),
    .rst     (rst),
    .flush   (redirect_vld),
    .pop_n   (pop_n),
    .push_n  (push_n),
    .push_d0 (push_d0),
    .push_d1 (push_d1),
    .cnt     (hb_cnt),
    .head0   (hb0),
    .head1   (hb1)
  );

  // Form the view: buffered halfwords followed by this cycle's fetched halfwords.
  always_comb begin
    inc_n = 2'd0;
    inc0  = imem_rdata[15:0];
    inc1  = imem_rdata[31:16];
    if (fetch_en) begin
      if (fetch_pc[1]) begin
        inc_n = 2'd1;
        inc0  = imem_rdata[31:16];
      end else begin
        inc_n = 2'd2;
      end
    end
    view_cnt = {1'b0, hb_cnt} + {1'b0, inc_n};
    view_pc  = (hb_cnt != 2'd0) ? buf_pc : fetch_pc;
    v0       = (hb_cnt != 2'd0) ? hb0 : inc0;
    case (hb_cnt)
      2'd0:    v1 = inc1;
      2'd1:    v1 = inc0;
      default: v1 = hb1;
    endcase
  end

  // Decide the issue and split consumed halfwords between buffer pops and skipped fetch data.
  always_comb begin
    head_c    = is_rvc(v0);
    head_ok   = head_c ? (view_cnt >= 3'd1) : (view_cnt >= 3'd2);
    slot_free = !if_valid || id_ready;
    issue     = slot_free && head_ok;
    take_n    = issue ? (head_c ? 2'd1 : 2'd2) : 2'd0;
    pop_n     = (take_n <= hb_cnt) ? take_n : hb_cnt;
    skip_n    = take_n - pop_n;
    push_n    = inc_n - skip_n;
    push_d0   = (skip_n == 2'd0) ? inc0 : inc1;
    push_d1   = inc1;
  end

  // Fetch PC, buffer head PC and IF/ID register; reset beats redirect beats issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      buf_pc   <= RESET_PC;
      if_valid <= 1'b0;
      if_instr <= 32'h0;
      if_is_c  <= 1'b0;
      if_pc    <= RESET_PC;
    end else if (redirect_vld) begin
      fetch_pc <= {redirect_pc[PC_W-1:1], 1'b0};
      if_valid <= 1'b0;
    end else begin
      if (fetch_en) begin
        fetch_pc <= (fetch_pc & ~PC_W'(3)) + PC_W'(4);
      end
      buf_pc <= view_pc + PC_W'({take_n, 1'b0});
      if (slot_free) begin
        if_valid <= head_ok;
        if (head_ok) begin
          if_instr <= head_c ? {16'h0000, v0} : {v1, v0};
          if_is_c  <= head_c;
          if_pc    <= view_pc;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_align.sv
// Directed bench for fetch_align: per-cycle vector tables plus hand sequences
// for stall, redirect and mid-stream reset.
module tb_fetch_align;

  logic        clk;
  logic        rst;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_we;
  logic        redirect_vld;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_instr;
  logic        if_is_c;
  logic [31:0] if_pc;

  logic [31:0] mem [0:1023];

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        ev;
    logic [31:0] ei;
    logic        ec;
    logic [31:0] ep;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] exp_q[$];
  logic        sb_on = 1'b0;
  logic [31:0] sb_exp;

  fetch_align #(
    .PC_W     (32),
    .IMEM_AW  (10),
    .RESET_PC (32'h0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_we      (imem_we),
    .redirect_vld (redirect_vld),
    .redirect_pc  (redirect_pc),
    .id_ready     (id_ready),
    .if_valid     (if_valid),
    .if_instr     (if_instr),
    .if_is_c      (if_is_c),
    .if_pc        (if_pc)
  );

  assign imem_rdata = mem[imem_addr];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    redirect_vld = 1'b0;
    redirect_pc  = 32'h0;
    id_ready     = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // memory images
  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0000_0013;
  endtask

  task automatic load_a();
    clear_mem();
    mem[0]    = 32'h4501_4585;
    mem[1]    = 32'h00a0_0093;
    mem[2]    = 32'h0010_0113;
    mem[3]    = 32'h0020_0193;
    mem[64]   = 32'h0093_0001;
    mem[65]   = 32'h4585_00a0;
    mem[1023] = 32'h0030_0213;
  endtask

  task automatic load_b();
    clear_mem();
    mem[0] = 32'h00a0_0093;
    mem[1] = 32'h0010_0113;
  endtask

  task automatic load_c();
    clear_mem();
    mem[0] = 32'h0093_4585;
    mem[1] = 32'h4501_00a0;
    mem[2] = 32'h0010_0113;
  endtask

  // driver: table rows
  task automatic add(input logic rv, input logic [31:0] rpc, input logic rdy,
                     input logic ev, input logic [31:0] ei, input logic ec,
                     input logic [31:0] ep);
    vec_t r;
    r.rv = rv; r.rpc = rpc; r.rdy = rdy;
    r.ev = ev; r.ei = ei; r.ec = ec; r.ep = ep;
    tbl.push_back(r);
  endtask

  task automatic run_table(input string name);
    for (int i = 0; i < tbl.size(); i++) begin
      redirect_vld = tbl[i].rv;
      redirect_pc  = tbl[i].rpc;
      id_ready     = tbl[i].rdy;
      tick();
      chk($sformatf("%s[%0d].valid", name, i), 32'(if_valid), 32'(tbl[i].ev));
      if (tbl[i].ev) begin
        chk($sformatf("%s[%0d].instr", name, i), if_instr, tbl[i].ei);
        chk($sformatf("%s[%0d].is_c", name, i), 32'(if_is_c), 32'(tbl[i].ec));
        chk($sformatf("%s[%0d].pc", name, i), if_pc, tbl[i].ep);
      end
    end
    tbl.delete();
    redirect_vld = 1'b0;
    redirect_pc  = 32'h0;
  endtask

  // scoreboard: PCs accepted by decode, in order
  always @(negedge clk) begin
    if (sb_on && !rst && !redirect_vld && if_valid && id_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_extra: got pc 0x%08h expected no transfer", if_pc);
      end else begin
        sb_exp = exp_q.pop_front();
        if (if_pc !== sb_exp) begin
          errors++;
          $display("FAIL sb_pc: got 0x%08h expected 0x%08h", if_pc, sb_exp);
        end
      end
    end
  end

  initial begin
    rst          = 1'b1;
    redirect_vld = 1'b0;
    redirect_pc  = 32'h0;
    id_ready     = 1'b1;

    // reset state, then aligned 32-bit stream
    load_b();
    do_reset();
    chk("rst.valid", 32'(if_valid), 32'h0);
    chk("rst.instr", if_instr, 32'h0);
    chk("rst.is_c", 32'(if_is_c), 32'h0);
    chk("rst.pc", if_pc, 32'h0);
    chk("rst.hb_cnt", 32'(dut.hb_cnt), 32'h0);
    chk("rst.addr", 32'(imem_addr), 32'h0);
    chk("rst.we", 32'(imem_we), 32'h0);
    add(0, 0, 1, 1, 32'h00a0_0093, 0, 32'h0);
    add(0, 0, 1, 1, 32'h0010_0113, 0, 32'h4);
    run_table("t1");
    chk("t1.addr", 32'(imem_addr), 32'h2);

    // two C instructions in one word, then 32-bit
    load_a();
    do_reset();
    add(0, 0, 1, 1, 32'h0000_4585, 1, 32'h0);
    add(0, 0, 1, 1, 32'h0000_4501, 1, 32'h2);
    add(0, 0, 1, 1, 32'h00a0_0093, 0, 32'h4);
    add(0, 0, 1, 1, 32'h0010_0113, 0, 32'h8);
    run_table("t2");

    // 32-bit instruction straddling a word boundary
    load_c();
    do_reset();
    add(0, 0, 1, 1, 32'h0000_4585, 1, 32'h0);
    add(0, 0, 1, 1, 32'h00a0_0093, 0, 32'h2);
    add(0, 0, 1, 1, 32'h0000_4501, 1, 32'h6);
    add(0, 0, 1, 1, 32'h0010_0113, 0, 32'h8);
    run_table("t3");

    // decode stall for 5 cycles, then resume without loss or duplicate
    load_a();
    do_reset();
    exp_q = '{32'h0, 32'h2, 32'h4, 32'h8};
    sb_on = 1'b1;
    tick();
    id_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("t4.stall%0d.valid", i), 32'(if_valid), 32'h1);
      chk($sformatf("t4.stall%0d.pc", i), if_pc, 32'h0);
      chk($sformatf("t4.stall%0d.instr", i), if_instr, 32'h0000_4585);
      chk($sformatf("t4.stall%0d.hb_cnt", i), 32'(dut.hb_cnt), 32'h3);
      chk($sformatf("t4.stall%0d.addr", i), 32'(imem_addr), 32'h2);
    end
    id_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    id_ready = 1'b0;
    sb_on    = 1'b0;
    chk("t4.sb_left", 32'(exp_q.size()), 32'h0);
    chk("t4.last.pc", if_pc, 32'hc);
    chk("t4.last.instr", if_instr, 32'h0020_0193);

    // redirect to a misaligned 32-bit target while stalled (bit 0 set, ignored)
    load_a();
    do_reset();
    add(0, 0,            0, 1, 32'h0000_4585, 1, 32'h0);
    add(0, 0,            0, 1, 32'h0000_4585, 1, 32'h0);
    add(1, 32'h0000_0103, 0, 0, 32'h0,         0, 32'h0);
    add(0, 0,            1, 0, 32'h0,         0, 32'h0);
    add(0, 0,            1, 1, 32'h00a0_0093, 0, 32'h102);
    add(0, 0,            1, 1, 32'h0000_4585, 1, 32'h106);
    run_table("t5");
    chk("t5.addr", 32'(imem_addr), 32'd67);

    // aligned and C-at-pc[1] redirects, and PC / address wrap-around
    load_a();
    do_reset();
    add(0, 0,            1, 1, 32'h0000_4585, 1, 32'h0);
    add(1, 32'h0000_0008, 1, 0, 32'h0,         0, 32'h0);
    add(0, 0,            1, 1, 32'h0010_0113, 0, 32'h8);
    add(1, 32'h0000_0002, 1, 0, 32'h0,         0, 32'h0);
    add(0, 0,            1, 1, 32'h0000_4501, 1, 32'h2);
    add(0, 0,            1, 1, 32'h00a0_0093, 0, 32'h4);
    add(1, 32'hffff_fffc, 1, 0, 32'h0,         0, 32'h0);
    add(0, 0,            1, 1, 32'h0030_0213, 0, 32'hffff_fffc);
    add(0, 0,            1, 1, 32'h0000_4585, 1, 32'h0);
    run_table("t_redir");

    // reset mid-stream with half an instruction buffered and a redirect pending
    load_c();
    do_reset();
    tick();
    chk("t6.pre.hb_cnt", 32'(dut.hb_cnt), 32'h1);
    rst          = 1'b1;
    redirect_vld = 1'b1;
    redirect_pc  = 32'h0000_0040;
    tick();
    chk("t6.valid", 32'(if_valid), 32'h0);
    chk("t6.pc", if_pc, 32'h0);
    chk("t6.instr", if_instr, 32'h0);
    chk("t6.is_c", 32'(if_is_c), 32'h0);
    chk("t6.hb_cnt", 32'(dut.hb_cnt), 32'h0);
    chk("t6.addr", 32'(imem_addr), 32'h0);
    rst          = 1'b0;
    redirect_vld = 1'b0;
    redirect_pc  = 32'h0;
    tick();
    chk("t6.post.valid", 32'(if_valid), 32'h1);
    chk("t6.post.pc", if_pc, 32'h0);
    chk("t6.post.instr", if_instr, 32'h0000_4585);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
